// File: rtl/seg7_scan_driver.sv
// Multiplexed common-anode seven-segment driver with a serial double-dabble BCD converter.
// Optional build macro: LEADING_ZERO_BLANK_EN (suppresses leading zero digits).
module seg7_scan_driver #(
  parameter int NUM_W    = 13,
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 262144
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_W-1:0]  num,
  input  logic              num_valid,
  output logic              num_ready,
  output logic              conv_done,
  output logic              overflow,
  output logic [DIGITS-1:0] Anode,
  output logic [6:0]        LED_out
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(NUM_W + 1);
  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t           state;
  logic [NUM_W-1:0] bin;
  logic [BCD_W-1:0] bcd;
  logic [BCD_W-1:0] bcd_adj;
  logic [BCD_W-1:0] digits;
  logic [CNT_W-1:0] count;
  logic             ovf;
  logic [PRE_W-1:0] presc;
  logic [IDX_W-1:0] idx;
  logic [3:0]       cur;
  logic             blank;

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // Anything carried out of the top nibble means the value needs more digits than we have.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      num_ready <= 1'b1;
      conv_done <= 1'b0;
      overflow  <= 1'b0;
      digits    <= '0;
      bin       <= '0;
      bcd       <= '0;
      count     <= '0;
      ovf       <= 1'b0;
    end else begin
      conv_done <= 1'b0;
      case (state)
        IDLE: begin
          if (num_valid) begin
            bin       <= num;
            bcd       <= '0;
            ovf       <= 1'b0;
            count     <= CNT_W'(NUM_W);
            num_ready <= 1'b0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          bcd   <= {bcd_adj[BCD_W-2:0], bin[NUM_W-1]};
          bin   <= bin << 1;
          ovf   <= ovf | bcd_adj[BCD_W-1];
          count <= count - 1'b1;
          if (count == CNT_W'(1)) state <= COMMIT;
        end
        COMMIT: begin
          digits    <= bcd;
          overflow  <= ovf;
          conv_done <= 1'b1;
          num_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
      idx   <= IDX_W'(DIGITS - 1);
    end else if (presc == PRE_W'(SCAN_DIV - 1)) begin
      presc <= '0;
      idx   <= (idx == '0) ? IDX_W'(DIGITS - 1) : idx - 1'b1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Digit select and blanking use loops so no select ever reaches past the digit register.
  always_comb begin
    cur   = 4'd0;
    blank = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      Anode[k] = (idx != IDX_W'(k));
      if (idx == IDX_W'(k)) cur = digits[4*k +: 4];
    end
`ifdef LEADING_ZERO_BLANK_EN
    begin
      logic lead;
      lead = 1'b1;
      for (int k = DIGITS - 1; k >= 1; k--) begin
        lead = lead & (digits[4*k +: 4] == 4'd0);
        if (idx == IDX_W'(k)) blank = lead;
      end
    end
`else
    blank = 1'b0;
`endif
    if (overflow) begin
      LED_out = 7'b1111110;
    end else if (blank) begin
      LED_out = 7'b1111111;
    end else begin
      case (cur)
        4'd0:    LED_out = 7'b0000001;
        4'd1:    LED_out = 7'b1001111;
        4'd2:    LED_out = 7'b0010010;
        4'd3:    LED_out = 7'b0000110;
        4'd4:    LED_out = 7'b1001100;
        4'd5:    LED_out = 7'b0100100;
        4'd6:    LED_out = 7'b0100000;
        4'd7:    LED_out = 7'b0001111;
        4'd8:    LED_out = 7'b0000000;
        4'd9:    LED_out = 7'b0000100;
        default: LED_out = 7'b0000001;
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: a 4-digit and a 3-digit instance, SCAN_DIV=4.
// Honours LEADING_ZERO_BLANK_EN when the expected segment patterns are built.
module tb_seg7_scan_driver;

  localparam int NW = 13;
  localparam int SD = 4;

  logic          clk = 1'b0;
  logic          rst4 = 1'b1, valid4 = 1'b0, ready4, done4, ovf4;
  logic [NW-1:0] num4 = '0;
  logic [3:0]    an4;
  logic [6:0]    led4;
  logic          rst3 = 1'b1, valid3 = 1'b0, ready3, done3, ovf3;
  logic [NW-1:0] num3 = '0;
  logic [2:0]    an3;
  logic [6:0]    led3;

  typedef struct packed {
    logic            ovf;
    logic [3:0][6:0] segs;
  } exp_t;

  exp_t q4[$];
  exp_t q3[$];
  exp_t cur4, cur3;
  int   checks = 0, fails = 0;
  int   tick4 = 0, tick3 = 0, idx4, idx3, dones4 = 0, dones3 = 0;
  bit   arm4 = 0, arm3 = 0, prev4 = 1, prev3 = 1;
  logic [3:0] ea4;
  logic [2:0] ea3;

  always #5 clk = ~clk;

  seg7_scan_driver #(.NUM_W(NW), .DIGITS(4), .SCAN_DIV(SD)) dut4 (
    .clk(clk), .rst(rst4), .num(num4), .num_valid(valid4), .num_ready(ready4),
    .conv_done(done4), .overflow(ovf4), .Anode(an4), .LED_out(led4));

  seg7_scan_driver #(.NUM_W(NW), .DIGITS(3), .SCAN_DIV(SD)) dut3 (
    .clk(clk), .rst(rst3), .num(num3), .num_valid(valid3), .num_ready(ready3),
    .conv_done(done3), .overflow(ovf3), .Anode(an3), .LED_out(led3));

  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd1:    return 7'b1001111;
      4'd2:    return 7'b0010010;
      4'd3:    return 7'b0000110;
      4'd4:    return 7'b1001100;
      4'd5:    return 7'b0100100;
      4'd6:    return 7'b0100000;
      4'd7:    return 7'b0001111;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0000100;
      default: return 7'b0000001;
    endcase
  endfunction

  // nib[3] is the most significant digit; unused digits of the 3-digit instance are 0.
  function automatic exp_t mk(input logic ovf, input logic [3:0][3:0] nib);
    exp_t e;
    bit   lead;
    lead  = 1'b1;
    e.ovf = ovf;
    for (int k = 3; k >= 0; k--) begin
      lead = lead && (nib[k] == 4'd0);
      if (ovf) e.segs[k] = 7'b1111110;
`ifdef LEADING_ZERO_BLANK_EN
      else if (lead && k != 0) e.segs[k] = 7'b1111111;
`endif
      else e.segs[k] = seg(nib[k]);
    end
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitors: pop on conv_done, then check scan position and lit digit every cycle.
  always @(negedge clk) begin
    if (prev4) begin
      tick4 = 0; cur4 = mk(1'b0, 16'd0); q4.delete(); arm4 = 1;
    end else if (arm4) begin
      tick4++;
    end
    if (arm4) begin
      if (done4 === 1'b1) begin
        dones4++;
        if (q4.size() == 0) checkOutput("unexpected_conv_done4", 32'd1, 32'd0);
        else cur4 = q4.pop_front();
      end
      idx4 = 3 - (tick4 / SD) % 4;
      ea4  = ~(4'b0001 << idx4);
      checkOutput("overflow4", ovf4, cur4.ovf);
      checkOutput("anode4", an4, ea4);
      checkOutput("led4", led4, cur4.segs[idx4]);
    end
    prev4 = rst4;
  end

  always @(negedge clk) begin
    if (prev3) begin
      tick3 = 0; cur3 = mk(1'b0, 16'd0); q3.delete(); arm3 = 1;
    end else if (arm3) begin
      tick3++;
    end
    if (arm3) begin
      if (done3 === 1'b1) begin
        dones3++;
        if (q3.size() == 0) checkOutput("unexpected_conv_done3", 32'd1, 32'd0);
        else cur3 = q3.pop_front();
      end
      idx3 = 2 - (tick3 / SD) % 3;
      ea3  = ~(3'b001 << idx3);
      checkOutput("overflow3", ovf3, cur3.ovf);
      checkOutput("anode3", an3, ea3);
      checkOutput("led3", led3, cur3.segs[idx3]);
    end
    prev3 = rst3;
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic applyStimulus(input int which, input logic [NW-1:0] v, input exp_t e, input bit hold);
    int   waitc;
    logic rdy;
    waitc = 0;
    if (which == 4) begin num4 = v; valid4 = 1'b1; end
    else begin num3 = v; valid3 = 1'b1; end
    @(negedge clk);
    rdy = (which == 4) ? ready4 : ready3;
    while (!rdy && waitc < 100) begin
      @(negedge clk);
      waitc++;
      rdy = (which == 4) ? ready4 : ready3;
    end
    if (!rdy) checkOutput("accept_timeout", 32'd0, 32'd1);
    if (which == 4) q4.push_back(e);
    else q3.push_back(e);
    @(posedge clk); #1;
    if (which == 4) valid4 = hold;
    else valid3 = hold;
  endtask

  task automatic waitReady(input int which, output int lowc);
    logic rdy;
    lowc = 0;
    @(negedge clk);
    rdy = (which == 4) ? ready4 : ready3;
    while (!rdy && lowc < 100) begin
      lowc++;
      @(negedge clk);
      rdy = (which == 4) ? ready4 : ready3;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lowc, d0, waitc;
    repeat (3) @(posedge clk);
    #1; rst4 = 1'b0; rst3 = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_reset4", ready4, 1);
    checkOutput("ready_after_reset3", ready3, 1);
    idle(20);

    applyStimulus(4, 13'd1234, mk(1'b0, {4'd1, 4'd2, 4'd3, 4'd4}), 1'b0);
    waitReady(4, lowc);
    checkOutput("busy_cycles_1234", lowc, 14);
    idle(20);

    applyStimulus(4, 13'd5, mk(1'b0, {4'd0, 4'd0, 4'd0, 4'd5}), 1'b1);
    applyStimulus(4, 13'd42, mk(1'b0, {4'd0, 4'd0, 4'd4, 4'd2}), 1'b0);
    waitReady(4, lowc);
    checkOutput("busy_cycles_42", lowc, 14);
    idle(20);

    applyStimulus(4, 13'd7, mk(1'b0, {4'd0, 4'd0, 4'd0, 4'd7}), 1'b0);
    waitReady(4, lowc);
    idle(20);
    applyStimulus(4, 13'd0, mk(1'b0, 16'd0), 1'b0);
    waitReady(4, lowc);
    idle(20);

    d0 = dones4;
    applyStimulus(4, 13'd8191, mk(1'b0, {4'd8, 4'd1, 4'd9, 4'd1}), 1'b0);
    idle(5);
    rst4 = 1'b1;
    idle(1);
    rst4 = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_abort", ready4, 1);
    idle(30);
    checkOutput("no_conv_done_after_abort", dones4, d0);

    applyStimulus(4, 13'd8191, mk(1'b0, {4'd8, 4'd1, 4'd9, 4'd1}), 1'b0);
    waitReady(4, lowc);
    idle(20);

    applyStimulus(3, 13'd999, mk(1'b0, {4'd0, 4'd9, 4'd9, 4'd9}), 1'b0);
    waitReady(3, lowc);
    idle(15);
    applyStimulus(3, 13'd1000, mk(1'b1, 16'd0), 1'b0);
    waitReady(3, lowc);
    idle(15);
    applyStimulus(3, 13'd0, mk(1'b0, 16'd0), 1'b0);
    waitReady(3, lowc);
    idle(15);

    waitc = 0;
    while ((q4.size() != 0 || q3.size() != 0) && waitc < 200) begin
      idle(1);
      waitc++;
    end
    checkOutput("scoreboard_drained", q4.size() + q3.size(), 0);
    idle(10);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
